// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - seven-segment glyph table and decode helper shared by encoder and capture
package ssd_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic {
    ST_TRACK = 1'b0,
    ST_HELD  = 1'b1
  } filt_state_t;

  typedef struct packed {
    logic [3:0] hex;
    logic       valid;
    logic       blank;
  } digit_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Returns {match, hex}; only exact glyph patterns match.
  function automatic logic [4:0] seg_to_hex(input seg_t s);
    logic [4:0] r;
    r = 5'h00;
    for (int i = 0; i < 16; i++) begin
      if (s == SEG_GLYPH[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_capture_if.sv
// rtl/ssd_capture_if.sv - multiplexed Pmod SSD lines as seen by driver and capture
interface ssd_capture_if;
  import ssd_pkg::*;

  seg_t seg;
  logic chip_sel;

  modport master (output seg, output chip_sel);
  modport slave  (input  seg, input  chip_sel);

endinterface

// File: rtl/ssd_stable_filter.sv
// rtl/ssd_stable_filter.sv - two-flop synchroniser plus TRACK/HELD stability filter
module ssd_stable_filter
  import ssd_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic             accept,
  output logic [WIDTH-1:0] sample
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [7:0]       stab_cnt;
  logic [7:0]       cnt_inc;
  logic             same;
  filt_state_t      state;

  assign same    = (sync2 == prev);
  assign cnt_inc = (stab_cnt == 8'hFF) ? stab_cnt : stab_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= 8'd0;
      state    <= ST_TRACK;
      accept   <= 1'b0;
      sample   <= '0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      prev   <= sync2;
      accept <= 1'b0;
      case (state)
        ST_TRACK: begin
          if (same) begin
            stab_cnt <= cnt_inc;
            if (cnt_inc == STABLE_CNT) begin
              accept <= 1'b1;
              sample <= sync2;
              state  <= ST_HELD;
            end
          end else begin
            stab_cnt <= 8'd1;
          end
        end
        ST_HELD: begin
          // One accept per stable interval; any change re-arms the filter.
          if (!same) begin
            stab_cnt <= 8'd1;
            state    <= ST_TRACK;
          end
        end
        default: state <= ST_TRACK;
      endcase
    end
  end

endmodule

// File: rtl/ssd_capture.sv
// rtl/ssd_capture.sv - recovers the two hex digits shown on a multiplexed Pmod SSD
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic         clk,
  input  logic         reset,
  ssd_capture_if.slave pmod,
  output logic [3:0]   digit_lo,
  output logic [3:0]   digit_hi,
  output logic         valid_lo,
  output logic         valid_hi,
  output logic         blank_lo,
  output logic         blank_hi,
  output logic         update,
  output logic         bad_pattern,
  output logic         stale
);

  localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic       acc;
  logic [7:0] sample;
  logic       sel;
  seg_t       pat;
  logic [4:0] dec;
  digit_t     lo_q, hi_q, cur, nxt;
  logic [TW-1:0] to_lo, to_hi, to_lo_n, to_hi_n;

  ssd_stable_filter #(
    .WIDTH         (8),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .din    ({pmod.chip_sel, pmod.seg}),
    .accept (acc),
    .sample (sample)
  );

  assign sel = sample[7];
  assign pat = sample[6:0];
  assign dec = seg_to_hex(pat);
  assign cur = sel ? hi_q : lo_q;

  always_comb begin
    nxt = cur;
    if (pat == SEG_BLANK) begin
      nxt.blank = 1'b1;
      nxt.valid = 1'b0;
    end else if (dec[4]) begin
      nxt.hex   = dec[3:0];
      nxt.valid = 1'b1;
      nxt.blank = 1'b0;
    end else begin
      nxt.valid = 1'b0;
      nxt.blank = 1'b0;
    end
  end

  // Per-digit refresh watchdogs, saturating at TMAX.
  always_comb begin
    to_lo_n = (to_lo == TMAX) ? to_lo : to_lo + 1'b1;
    to_hi_n = (to_hi == TMAX) ? to_hi : to_hi + 1'b1;
    if (acc && !sel) to_lo_n = '0;
    if (acc && sel)  to_hi_n = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q        <= '0;
      hi_q        <= '0;
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      stale       <= 1'b0;
      to_lo       <= '0;
      to_hi       <= '0;
    end else begin
      update <= 1'b0;
      to_lo  <= to_lo_n;
      to_hi  <= to_hi_n;
      stale  <= (to_lo_n == TMAX) || (to_hi_n == TMAX);
      if (acc) begin
        if (sel) hi_q <= nxt;
        else     lo_q <= nxt;
        update <= (nxt != cur);
        if (!dec[4] && pat != SEG_BLANK) bad_pattern <= 1'b1;
      end
    end
  end

  assign digit_lo = lo_q.hex;
  assign valid_lo = lo_q.valid;
  assign blank_lo = lo_q.blank;
  assign digit_hi = hi_q.hex;
  assign valid_hi = hi_q.valid;
  assign blank_hi = hi_q.blank;

endmodule

// File: tb/tb_ssd_capture.sv
// tb/tb_ssd_capture.sv - directed vector bench for ssd_capture
module tb_ssd_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_lo, digit_hi;
  logic       valid_lo, valid_hi, blank_lo, blank_hi;
  logic       update, bad_pattern, stale;

  int total = 0;
  int bad   = 0;

  ssd_capture_if bus ();

  ssd_capture #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pmod        (bus),
    .digit_lo    (digit_lo),
    .digit_hi    (digit_hi),
    .valid_lo    (valid_lo),
    .valid_hi    (valid_hi),
    .blank_lo    (blank_lo),
    .blank_hi    (blank_hi),
    .update      (update),
    .bad_pattern (bad_pattern),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic [6:0] seg;
    int         hold;
    logic [3:0] dlo, dhi;
    logic       vlo, vhi, blo, bhi, bp;
    int         upd;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold_count(input int n, output int upd);
    upd = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (update) upd++;
    end
  endtask

  task automatic wait_update(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (update) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int upd, cyc, first;

    tbl[0]  = '{1'b0, 7'h06, 40,  4'h1, 4'h0, 1, 0, 0, 0, 0, 1};
    tbl[1]  = '{1'b0, 7'h3F, 100, 4'h0, 4'h0, 1, 0, 0, 0, 0, 1};
    tbl[2]  = '{1'b1, 7'h71, 100, 4'h0, 4'hF, 1, 1, 0, 0, 0, 1};
    tbl[3]  = '{1'b0, 7'h3F, 100, 4'h0, 4'hF, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 7'h71, 100, 4'h0, 4'hF, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 7'h06, 40,  4'h1, 4'hF, 1, 1, 0, 0, 0, 1};
    tbl[6]  = '{1'b0, 7'h7F, 10,  4'h1, 4'hF, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1'b0, 7'h06, 40,  4'h1, 4'hF, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 7'h01, 40,  4'h1, 4'hF, 1, 0, 0, 0, 1, 1};
    tbl[9]  = '{1'b1, 7'h00, 40,  4'h1, 4'hF, 1, 0, 0, 1, 1, 1};
    tbl[10] = '{1'b1, 7'h5B, 40,  4'h1, 4'h2, 1, 1, 0, 0, 1, 1};
    tbl[11] = '{1'b0, 7'h00, 40,  4'h1, 4'h2, 0, 1, 1, 0, 1, 1};
    tbl[12] = '{1'b0, 7'h4F, 40,  4'h3, 4'h2, 1, 1, 0, 0, 1, 1};
    tbl[13] = '{1'b1, 7'h4F, 40,  4'h3, 4'h3, 1, 1, 0, 0, 1, 1};

    bus.seg      = 7'h00;
    bus.chip_sel = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {digit_lo, digit_hi, valid_lo, valid_hi, blank_lo, blank_hi,
                        update, bad_pattern, stale}, 0);

    // Table pass: change inputs on a negedge, hold, then compare.
    bus.seg = tbl[0].seg;
    reset   = 1'b0;
    for (int v = 0; v < 14; v++) begin
      bus.chip_sel = tbl[v].cs;
      bus.seg      = tbl[v].seg;
      hold_count(tbl[v].hold, upd);
      chk($sformatf("v%0d_digit_lo", v), digit_lo, tbl[v].dlo);
      chk($sformatf("v%0d_digit_hi", v), digit_hi, tbl[v].dhi);
      chk($sformatf("v%0d_valid_lo", v), valid_lo, tbl[v].vlo);
      chk($sformatf("v%0d_valid_hi", v), valid_hi, tbl[v].vhi);
      chk($sformatf("v%0d_blank_lo", v), blank_lo, tbl[v].blo);
      chk($sformatf("v%0d_blank_hi", v), blank_hi, tbl[v].bhi);
      chk($sformatf("v%0d_bad_pattern", v), bad_pattern, tbl[v].bp);
      chk($sformatf("v%0d_updates", v), upd, tbl[v].upd);
    end

    // Reset after a partial stable interval: count discarded, then exact accept latency.
    bus.chip_sel = 1'b0;
    bus.seg      = 7'h3F;
    hold_count(10, upd);
    chk("pre_reset_updates", upd, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {digit_lo, digit_hi, valid_lo, valid_hi, blank_lo, blank_hi,
                              update, bad_pattern, stale}, 0);
    reset = 1'b0;
    wait_update(100, cyc);
    chk("post_reset_latency", cyc, 19);
    chk("post_reset_digit_lo", digit_lo, 0);
    chk("post_reset_valid_lo", valid_lo, 1);
    chk("post_reset_valid_hi", valid_hi, 0);

    // Stale: refresh lo only, hi watchdog must expire after 1000 cycles.
    reset = 1'b1;
    @(negedge clk);
    bus.chip_sel = 1'b0;
    bus.seg      = 7'h06;
    reset        = 1'b0;
    first        = 0;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (stale && first == 0) first = c;
      if (c % 50 == 0) bus.seg = (bus.seg == 7'h06) ? 7'h5B : 7'h06;
    end
    chk("stale_assert_cycle", first, 1000);
    chk("stale_still_high", stale, 1);

    bus.chip_sel = 1'b1;
    bus.seg      = 7'h66;
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (!stale) begin
        cyc = i;
        break;
      end
    end
    chk("stale_clear_cycle", cyc, 19);
    chk("stale_hi_digit", digit_hi, 4);
    chk("stale_hi_valid", valid_hi, 1);

    // Unchanged input far beyond STABLE_CYCLES accepts only once.
    hold_count(300, upd);
    chk("held_no_reaccept", upd, 0);
    chk("held_digit_hi", digit_hi, 4);
    chk("held_stale_low", stale, 0);
    chk("held_bad_pattern", bad_pattern, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
